// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one LSB-first full-adder step per clock.
// Results latch on DONE entry and hold until the next operation completes.
module serial_adder #(
  parameter int WIDTH  = 8,
  parameter bit SUB_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             eff_sub, s_bit, c_next;
  logic [WIDTH-1:0] res_next;

  assign eff_sub  = SUB_EN && sub;
  assign s_bit    = a_sr[0] ^ b_sr[0] ^ c;
  assign c_next   = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);
  // Sum bits enter at the MSB so the last step leaves the result aligned.
  assign res_next = (res_sr >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      c         <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= eff_sub ? ~b : b;
            c     <= eff_sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          res_sr <= res_next;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          c      <= c_next;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            // c still holds the carry into the MSB on this final step
            sum       <= res_next;
            carry_out <= c_next;
            overflow  <= c ^ c_next;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8, SUB_EN=1); inputs driven and
// outputs sampled on the falling edge.
module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst, start, sub;
  logic [7:0] a, b;
  logic       busy, done, carry_out, overflow;
  logic [7:0] sum;

  int vectors = 0;
  int errors  = 0;

  serial_adder #(.WIDTH(8), .SUB_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .sub(sub),
    .busy(busy), .done(done), .sum(sum), .carry_out(carry_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = 8'hAA; b = 8'h55; sub = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, sum, carry_out, overflow} !== 11'd0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b sum=%h co=%b ov=%b, want all zero",
               busy, done, sum, carry_out, overflow);
    end
    rst = 1'b0;
  endtask

  // Drives one op at k=0; done must appear at k=9, busy for k=1..8.
  task automatic test_arith(input logic [7:0] va, input logic [7:0] vb, input logic vs,
                            input logic [7:0] es, input logic ec, input logic ev,
                            input string name);
    int busy_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        vectors++;
        if (busy !== (k <= 8) || done !== (k == 9)) begin
          errors++;
          $display("FAIL %s_timing k=%0d: got busy=%b done=%b, want busy=%b done=%b",
                   name, k, busy, done, k <= 8, k == 9);
        end
        if (busy === 1'b1) busy_cnt++;
      end
      if (k == 9) begin
        vectors++;
        if (sum !== es || carry_out !== ec || overflow !== ev) begin
          errors++;
          $display("FAIL %s_result: got sum=%h co=%b ov=%b, want sum=%h co=%b ov=%b",
                   name, sum, carry_out, overflow, es, ec, ev);
        end
      end
      start = (k == 0);
      a = (k == 0) ? va : 8'hC3;
      b = (k == 0) ? vb : 8'h3C;
      sub = (k == 0) ? vs : ~vs;
    end
    vectors++;
    if (busy_cnt != 8) begin
      errors++;
      $display("FAIL %s_busy_len: got %0d cycles, want 8", name, busy_cnt);
    end
  endtask

  task automatic test_add();
    test_arith(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, "add_0f_01");
    test_arith(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
    test_arith(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "add_7f_01");
    test_arith(8'h3C, 8'hC4, 1'b0, 8'h00, 1'b1, 1'b0, "add_3c_c4");
  endtask

  task automatic test_sub();
    test_arith(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_05_07");
    test_arith(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_01");
    test_arith(8'h10, 8'h10, 1'b1, 8'h00, 1'b1, 1'b0, "sub_10_10");
  endtask

  task automatic test_start_ignored();
    int dones = 0;
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
      if (k == 9) begin
        vectors++;
        if (done !== 1'b1 || sum !== 8'h10) begin
          errors++;
          $display("FAIL ignore_start_result: got done=%b sum=%h, want done=1 sum=10", done, sum);
        end
      end
      start = (k == 0) || (k == 3);
      a = (k == 3) ? 8'h55 : 8'h0F;
      b = (k == 3) ? 8'h55 : 8'h01;
      sub = 1'b0;
    end
    vectors++;
    if (dones != 1) begin
      errors++;
      $display("FAIL ignore_start_dones: got %0d done pulses, want 1", dones);
    end
  endtask

  task automatic test_reset_midrun();
    int dones = 0;
    for (int k = 0; k < 27; k++) begin
      @(negedge clk);
      if (k == 5) begin
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00) begin
          errors++;
          $display("FAIL midrun_reset: got busy=%b done=%b sum=%h, want 0 0 00", busy, done, sum);
        end
      end
      if (k >= 6 && k <= 16 && done === 1'b1) dones++;
      if (k == 25) begin
        vectors++;
        if (done !== 1'b1 || sum !== 8'h05 || carry_out !== 1'b0 || overflow !== 1'b0) begin
          errors++;
          $display("FAIL after_reset_add: got done=%b sum=%h co=%b ov=%b, want 1 05 0 0",
                   done, sum, carry_out, overflow);
        end
      end
      rst   = (k == 4);
      start = (k == 0) || (k == 16);
      a = (k == 16) ? 8'h02 : 8'h0F;
      b = (k == 16) ? 8'h03 : 8'h01;
      sub = 1'b0;
    end
    vectors++;
    if (dones != 0) begin
      errors++;
      $display("FAIL midrun_no_done: got %0d done pulses, want 0", dones);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ta [3] = '{8'h12, 8'hF0, 8'h40};
    logic [7:0] tb [3] = '{8'h34, 8'h0F, 8'h40};
    logic       ts [3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] es [3] = '{8'h46, 8'hE1, 8'h80};
    logic       ec [3] = '{1'b0, 1'b1, 1'b0};
    logic       ev [3] = '{1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 31; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        vectors++;
        if (done !== (k % 10 == 9)) begin
          errors++;
          $display("FAIL b2b_done k=%0d: got %b, want %b", k, done, k % 10 == 9);
        end
      end
      if (k % 10 == 9) begin
        vectors++;
        if (sum !== es[k/10] || carry_out !== ec[k/10] || overflow !== ev[k/10]) begin
          errors++;
          $display("FAIL b2b_result%0d: got sum=%h co=%b ov=%b, want sum=%h co=%b ov=%b",
                   k / 10, sum, carry_out, overflow, es[k/10], ec[k/10], ev[k/10]);
        end
      end
      if (k == 15) begin
        vectors++;
        if (sum !== 8'h46 || busy !== 1'b1) begin
          errors++;
          $display("FAIL b2b_hold: got sum=%h busy=%b, want sum=46 busy=1", sum, busy);
        end
      end
      start = 1'b1;
      a   = (k % 10 == 0 && k < 30) ? ta[k/10] : 8'hAA;
      b   = (k % 10 == 0 && k < 30) ? tb[k/10] : 8'h55;
      sub = (k % 10 == 0 && k < 30) ? ts[k/10] : 1'b1;
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_start_ignored();
    test_reset_midrun();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal range 1 to 64.
REQ-002 Parameter SUB_EN, default 1, enables subtract mode; when 0 the sub input is ignored and treated as 0.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  request a new operation; sampled only in IDLE.
REQ-006 a  input  WIDTH  operand A, captured on the accepting edge.
REQ-007 b  input  WIDTH  operand B, captured on the accepting edge.
REQ-008 sub  input  1  0 = A+B, 1 = A-B; captured with the operands.
REQ-009 busy  output  1  high while bits are being processed (RUN).
REQ-010 done  output  1  one-cycle pulse; results are valid from this cycle onward.
REQ-011 sum  output  WIDTH  result of the last completed operation.
REQ-012 carry_out  output  1  carry out of the MSB; for subtract, 1 = no borrow (A >= B unsigned).
REQ-013 overflow  output  1  two's-complement overflow of the last completed operation.

Function
REQ-014 The FSM SHALL have three states, IDLE, RUN and DONE, encoded in registers.
REQ-015 In IDLE with start=1 at edge N, the block SHALL:
- capture a into the A shift register;
- capture b (or ~b when sub=1 and SUB_EN=1) into the B shift register;
- set the carry flop to the effective sub value;
- clear the bit counter;
- enter RUN.
REQ-016 In RUN, each edge SHALL process one bit LSB-first with a 1-bit full adder:
- sum bit = a0 ^ b0 ^ c, carry = majority(a0, b0, c);
- the sum bit SHALL shift into the result shift register at its MSB end;
- the A and B registers SHALL shift right by one;
- the counter SHALL increment.
REQ-017 The RUN state SHALL last exactly WIDTH cycles (edges N+1 to N+WIDTH), then transition to DONE.
REQ-018 On the edge entering DONE, the block SHALL load sum, carry_out and overflow.
- overflow = carry into the MSB XOR carry out of the MSB.
REQ-019 DONE SHALL last exactly one cycle, with done=1 and busy=0, then return to IDLE unconditionally.
REQ-020 busy SHALL be 1 only in RUN.
REQ-021 Latency SHALL be WIDTH+1 cycles from the accepting edge to the done cycle, and the block SHALL accept a new operation every WIDTH+2 cycles at most.
REQ-022 start asserted in RUN or DONE SHALL be ignored and never queued; the operand inputs SHALL be don't-care outside the accepting edge.
REQ-023 sum, carry_out and overflow SHALL hold stable from done until the next DONE entry, including while a later operation runs.
REQ-024 For WIDTH=1, RUN SHALL last one cycle and overflow SHALL equal carry-in XOR carry-out of bit 0.
REQ-025 The counter width SHALL be clog2(WIDTH+1); wrap-around SHALL never occur because RUN exits at count WIDTH-1.
REQ-026 Arithmetic SHALL be modulo 2^WIDTH, with no saturation.

Reset
REQ-027 rst=1 at any edge SHALL force IDLE and zero all of the following: busy, done, sum, carry_out, overflow, the counter, the carry flop and the shift registers.
REQ-028 rst SHALL have priority over start; an operation interrupted by reset SHALL be discarded and SHALL NOT produce done.
REQ-029 The first start after rst deasserts SHALL be accepted normally on the first edge with rst=0.

Verification (WIDTH=8, SUB_EN=1)
REQ-030 The bench SHALL cover the following directed scenarios:
- Add 8'h0F+8'h01: busy is high for exactly 8 cycles, done pulses once 9 cycles after the start edge; sum=8'h10, carry_out=0, overflow=0.
- Add 8'hFF+8'h01: sum=8'h00, carry_out=1, overflow=0. Add 8'h7F+8'h01: sum=8'h80, carry_out=0, overflow=1.
- Sub 8'h05-8'h07: sum=8'hFE, carry_out=0, overflow=0. Sub 8'h80-8'h01: sum=8'h7F, carry_out=1, overflow=1.
- start pulsed during RUN with different operands: ignored; the result matches the first operands and exactly one done pulse occurs.
- rst asserted on the 4th RUN edge: next cycle busy=0, done=0, sum=0; no done follows; a subsequent add 8'h02+8'h03 gives 8'h05.
- Back-to-back: start held high continuously; done pulses every 10 cycles and each result matches the operands present on its accepting edge.
